// File: rtl/lsu_wb_master.sv
// -----------------------------------------------------------------------------
// lsu_wb_master
//
// Load/store unit placed directly upstream of the core's Wishbone data memory
// slave. It accepts one MEM-stage request at a time and runs one Wishbone
// classic cycle for it:
//   - stores: drives byte-lane selects and lane-replicated write data;
//   - loads : captures the slave's registered read data (valid the cycle
//             after ack), then extracts and sign/zero-extends the addressed
//             byte, halfword or word;
//   - misaligned halfword/word accesses complete without touching the bus.
// The pipeline is stalled (busy_o) until the one-cycle rsp_valid_o pulse.
//
// Optional feature (compile-time macro LSU_BUS_TIMEOUT_EN):
//   when defined, a REQ-state cycle counter aborts an unacknowledged cycle
//   after TIMEOUT_CYCLES cycles and reports bus_err_o; when undefined, REQ
//   waits indefinitely and bus_err_o is tied low.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_valid_i .. req_unsigned_i   MEM-stage request (held until rsp_valid_o)
//   busy_o                stall to the pipeline
//   rsp_valid_o           one-cycle completion pulse
//   rsp_rdata_o           extended load data (0 for stores/misaligned/errors)
//   misalign_o, bus_err_o status, valid with rsp_valid_o
//   wb_cyc_o .. wb_dat_o  Wishbone master outputs (all registered)
//   wb_dat_i, wb_ack_i    Wishbone slave read data (registered) and ack
// -----------------------------------------------------------------------------
module lsu_wb_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        busy_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Wishbone output registers (cyc and stb always move together)
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;

  // Response registers
  logic        rsp_valid_q, rsp_valid_d;
  logic        misalign_q, misalign_d;
  logic [31:0] rdata_q, rdata_d;

  // Latched request fields needed later for load extraction
  logic [1:0]  off_q, off_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;

  logic        req_misaligned;
  logic        tmo_expired;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Size 2'b11 is handled exactly like a word.
  function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_sel(input logic [1:0] off, input logic [1:0] size);
    logic [3:0] r;
    case (size)
      2'b00:   r = 4'b0001 << off;
      2'b01:   r = 4'b0011 << {off[1], 1'b0};
      default: r = 4'b1111;
    endcase
    return r;
  endfunction

  // Replicating the data onto every lane lets the slave pick it up through
  // wb_sel_o alone, whatever the offset.
  function automatic logic [31:0] lane_data(input logic [31:0] wdata, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{wdata[7:0]}};
      2'b01:   r = {2{wdata[15:0]}};
      default: r = wdata;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h}   : {{16{h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  assign req_misaligned = is_misaligned(req_addr_i[1:0], req_size_i);

  // ---------------------------------------------------------------------------
  // Optional bus timeout
  // ---------------------------------------------------------------------------
`ifdef LSU_BUS_TIMEOUT_EN
  // Counter only has to reach TIMEOUT_CYCLES-1: REQ is left on that value.
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             bus_err_q, bus_err_d;

  assign tmo_expired = (state_q == REQ) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Timeout counter and bus error flag next-state; an ack in the expiry cycle wins.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          tmo_cnt_d = {TMO_W{1'b0}};
          bus_err_d = 1'b0;
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
      end
      REQ: begin
        if (!wb_ack_i && !tmo_expired) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end else begin
          tmo_cnt_d = tmo_cnt_q;
        end
        bus_err_d = !wb_ack_i && tmo_expired;
      end
      RESP:    bus_err_d = 1'b0;
      default: bus_err_d = bus_err_q;
    endcase
  end

  // Timeout counter and bus error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= {TMO_W{1'b0}};
      bus_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err_o = bus_err_q;
`else
  assign tmo_expired = 1'b0;
  assign bus_err_o   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          state_d = req_misaligned ? RESP : REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (wb_ack_i) begin
          state_d = we_q ? RESP : RDATA;
        end else if (tmo_expired) begin
          state_d = RESP;
        end else begin
          state_d = REQ;
        end
      end
      RDATA:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered bus and response outputs.
  always_comb begin
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    sel_d       = sel_q;
    dat_d       = dat_q;
    rsp_valid_d = 1'b0;
    misalign_d  = misalign_q;
    rdata_d     = rdata_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          off_d      = req_addr_i[1:0];
          size_d     = req_size_i;
          uns_d      = req_unsigned_i;
          rdata_d    = 32'h0000_0000;
          misalign_d = req_misaligned;
          if (req_misaligned) begin
            rsp_valid_d = 1'b1;
          end else begin
            cyc_d = 1'b1;
            we_d  = req_we_i;
            adr_d = {req_addr_i[31:2], 2'b00};
            sel_d = lane_sel(req_addr_i[1:0], req_size_i);
            dat_d = lane_data(req_wdata_i, req_size_i);
          end
        end else begin
          cyc_d = 1'b0;
        end
      end
      REQ: begin
        if (wb_ack_i) begin
          cyc_d       = 1'b0;
          rsp_valid_d = we_q;
        end else if (tmo_expired) begin
          cyc_d       = 1'b0;
          rsp_valid_d = 1'b1;
        end else begin
          cyc_d = 1'b1;
        end
      end
      RDATA: begin
        // Slave data is registered, so it is valid here, one cycle after ack.
        rdata_d     = load_extract(wb_dat_i, off_q, size_q, uns_q);
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        misalign_d = 1'b0;
      end
      default: begin
        cyc_d = 1'b0;
      end
    endcase
  end

  // Bus, response and latched-request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= 32'h0000_0000;
      sel_q       <= 4'b0000;
      dat_q       <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      off_q       <= 2'b00;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
    end else begin
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      sel_q       <= sel_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      misalign_q  <= misalign_d;
      rdata_q     <= rdata_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign wb_we_o     = we_q;
  assign wb_adr_o    = adr_q;
  assign wb_sel_o    = sel_q;
  assign wb_dat_o    = dat_q;
  assign rsp_valid_o = rsp_valid_q;
  assign misalign_o  = misalign_q;
  assign rsp_rdata_o = rdata_q;
  assign busy_o      = req_valid_i & ~rsp_valid_q;

endmodule
